apb_master_fsm: RTL and testbench
=================================

// Module: apb_master_fsm
// PURPOSE
//  Second-generation APB-side controller of the AHB2APB bridge. Turns one accepted AHB transfer
//  into one APB SETUP/ACCESS transfer, with parametrised address/data width and slave count.
//  Adds PREADY wait states, PSLVERR and timeout error reporting, and the two-cycle AHB ERROR response.
//  Sits between the AHB slave interface (address/select decode) and the APB peripheral bus.
// PARAMETERS
//  ADDR_W   32  address width (Haddr, Paddr)
//  DATA_W   32  data width (Hwdata, Hrdata, Prdata, Pwdata)
//  NSLV     3   number of APB slaves; width of tempselx and Pselx (one-hot)
//  TIMEOUT  16  max ACCESS cycles with Pready=0 before abort; 0 disables the timeout
// PORTS
//  Hclk       in   1       bridge clock; all logic is rising-edge
//  Hresetn    in   1       synchronous active-low reset
//  valid      in   1       AHB transfer request (decoded NONSEQ/SEQ, Hsel active)
//  Haddr      in   ADDR_W  AHB address, sampled with valid
//  Hwrite     in   1       1 = write, sampled with valid
//  tempselx   in   NSLV    one-hot slave select from the decoder, sampled with valid
//  Hwdata     in   DATA_W  write data; AHB data phase, one cycle after acceptance
//  Prdata     in   DATA_W  APB read data
//  Pready     in   1       APB slave ready
//  Pslverr    in   1       APB slave error, qualified by Penable & Pready
//  Paddr      out  ADDR_W  APB address (registered)
//  Pwdata     out  DATA_W  APB write data (registered)
//  Pwrite     out  1       APB direction (registered)
//  Pselx      out  NSLV    APB one-hot select (registered)
//  Penable    out  1       APB enable (registered)
//  Hreadyout  out  1       AHB ready (registered)
//  Hresp      out  1       AHB response, 0 = OKAY, 1 = ERROR (registered)
//  Hrdata     out  DATA_W  read data returned to AHB (registered)
// BEHAVIOUR
//  Reset (Hresetn=0 at a rising edge): state=IDLE; Hreadyout=1; all other outputs 0; timeout count 0.
//   Reset mid-transfer aborts it at that edge. Pselx/Penable drop with no completion and no error.
//  States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
//  IDLE: Hreadyout=1, Hresp=0. Accept when valid & Hreadyout; at that edge Haddr, Hwrite and
//   tempselx are latched into Paddr, Pwrite and a select register.
//   tempselx==0 (unmapped) -> ERR1; no APB activity. tempselx with >1 bit set is also treated as unmapped.
//   Write -> WDATA. Read -> SETUP.
//  WDATA: Hreadyout=0; Pwdata<=Hwdata; -> SETUP.
//  SETUP: Pselx=latched select, Penable=0, Hreadyout=0; -> ACCESS unconditionally.
//  ACCESS: Pselx held, Penable=1; Paddr, Pwrite and Pwdata stable from SETUP through completion.
//   Pready=1 & Pslverr=0 -> IDLE. At that edge Hreadyout<=1, Pselx/Penable<=0, and for reads
//    Hrdata<=Prdata.
//   Pready=1 & Pslverr=1 -> ERR1. Hrdata is not updated.
//   Pready=0 -> stay in ACCESS, increment the wait counter.
//    When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with Pready still 0 -> ERR1; Pselx/Penable drop.
//  ERR1: Hresp=1, Hreadyout=0; -> ERR2.  ERR2: Hresp=1, Hreadyout=1; -> IDLE (Hresp=0).
//  Latency, zero wait states, first-accept edge to Hreadyout=1:
//   read 3 edges (accept -> SETUP -> ACCESS -> IDLE); write 4 edges (adds WDATA).
//  valid is ignored whenever Hreadyout=0. Back-to-back transfers: valid held in IDLE is accepted
//   on the same edge Hreadyout is seen high, so no idle cycle is inserted.
//  Wait counter: width clog2(TIMEOUT+1); cleared on entry to SETUP; saturates, never wraps.
//  Hrdata holds its last value until the next successful read completes.
// STRUCTURE
//  Shared package apb_ctrl_pkg: state encoding (3-bit localparams), HRESP_OKAY/HRESP_ERROR,
//   and the one-hot check function.
//  One natural sub-module: apb_wait_timer. Inputs: clear, count enable (ACCESS & ~Pready),
//   TIMEOUT param. Output: expired.
//  All outputs come straight from flops; no combinational path from Pready/Prdata to AHB outputs.
// TESTING
//  Read, 0 waits: valid=1, Hwrite=0, Haddr=32'h8400_0000, tempselx=3'b010, Prdata=32'hCAFE_F00D, Pready=1
//   -> Pselx=010 for 2 cycles, Penable in the 2nd, Hreadyout=1 and Hrdata=CAFE_F00D 3 edges after accept.
//  Write, 3 waits: Haddr=32'h8000_0000, tempselx=3'b001, Hwdata=32'h1234_5678 one cycle later,
//   Pready low for 3 ACCESS cycles -> Pwdata=1234_5678 stable, Penable high 4 cycles, Hresp=0.
//  Slave error: read with Pslverr=1 & Pready=1 in ACCESS -> Hresp=1 for 2 cycles, Hreadyout 0 then 1,
//   Hrdata unchanged.
//  Timeout: TIMEOUT=4, Pready tied 0 -> Pselx/Penable drop after 4 ACCESS cycles, then ERR1/ERR2 response.
//  Unmapped: valid=1, tempselx=3'b000 -> Pselx stays 0, two-cycle ERROR; tempselx=3'b011 -> same.
//  Reset mid-ACCESS: Hresetn=0 for 1 edge during a wait state -> next cycle all outputs 0, Hreadyout=1,
//   and a new transfer is accepted normally.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared definitions for the APB-side bridge controller: state encoding,
// AHB response codes and the slave-select sanity check.
package apb_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WDATA  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_ERR1   = 3'd4;
    localparam logic [2:0] ST_ERR2   = 3'd5;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Widest slave-select vector the one-hot check accepts.
    localparam int MAX_NSLV = 32;

    function automatic logic is_onehot(input logic [MAX_NSLV-1:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on PREADY and flags the cycle on which
// the wait budget runs out. TIMEOUT of 0 never expires.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating count so a disabled timeout can never wrap into a false expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_master_fsm.sv
// APB-side controller of the AHB2APB bridge: one accepted AHB transfer becomes
// one APB SETUP/ACCESS transfer, with wait states, slave/timeout errors and the
// two-cycle AHB ERROR response. Every output is driven directly from a flop.
module apb_master_fsm #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [NSLV-1:0]   tempselx,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Pwrite,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Hreadyout,
    output logic              Hresp,
    output logic [DATA_W-1:0] Hrdata
);
    import apb_ctrl_pkg::*;

    logic [2:0]        state_q, state_d;
    logic [NSLV-1:0]   sel_q, sel_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [NSLV-1:0]   pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;

    logic accept;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign accept      = (state_q == ST_IDLE) && valid && hreadyout_q;
    assign timer_clear = (state_d == ST_SETUP);
    assign timer_en    = (state_q == ST_ACCESS) && !Pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (Hclk),
        .rst_n     (Hresetn),
        .clear_i   (timer_clear),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // A select with zero or several bits set has no single target slave.
                    if (!is_onehot(MAX_NSLV'(tempselx))) begin
                        state_d = ST_ERR1;
                    end else if (Hwrite) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_WDATA:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (Pready) begin
                    state_d = Pslverr ? ST_ERR1 : ST_IDLE;
                end else if (timer_expired) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        sel_d       = accept ? tempselx : sel_q;
        paddr_d     = accept ? Haddr : paddr_q;
        pwrite_d    = accept ? Hwrite : pwrite_q;
        pwdata_d    = (state_q == ST_WDATA) ? Hwdata : pwdata_q;
        pselx_d     = ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) ? sel_d : '0;
        penable_d   = (state_d == ST_ACCESS);
        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        hrdata_d    = hrdata_q;
        if ((state_q == ST_ACCESS) && Pready && !Pslverr && !pwrite_q) begin
            hrdata_d = Prdata;
        end
    end

    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Pwrite    = pwrite_q;
    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Hreadyout = hreadyout_q;
    assign Hresp     = hresp_q;
    assign Hrdata    = hrdata_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: a per-cycle vector table for the main
// transfer types plus hand-written timeout and mid-transfer reset sequences.
module tb_apb_master_fsm;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NSLV    = 3;
    localparam int TIMEOUT = 4;

    logic              Hclk;
    logic              Hresetn;
    logic              valid;
    logic [ADDR_W-1:0] Haddr;
    logic              Hwrite;
    logic [NSLV-1:0]   tempselx;
    logic [DATA_W-1:0] Hwdata;
    logic [DATA_W-1:0] Prdata;
    logic              Pready;
    logic              Pslverr;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Pwrite;
    logic [NSLV-1:0]   Pselx;
    logic              Penable;
    logic              Hreadyout;
    logic              Hresp;
    logic [DATA_W-1:0] Hrdata;

    int checks   = 0;
    int failures = 0;

    apb_master_fsm #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NSLV    (NSLV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .valid     (valid),
        .Haddr     (Haddr),
        .Hwrite    (Hwrite),
        .tempselx  (tempselx),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Pwrite    (Pwrite),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        string       name;
        logic        valid;
        logic        hwrite;
        logic [31:0] haddr;
        logic [2:0]  sel;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
        logic [2:0]  e_psel;
        logic        e_pen;
        logic        e_hready;
        logic        e_hresp;
        logic        e_pwrite;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [31:0] e_hrdata;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] A_RD0  = 32'h8400_0000;
    localparam logic [31:0] A_WR3  = 32'h8000_0000;
    localparam logic [31:0] A_SERR = 32'h8400_0004;
    localparam logic [31:0] A_UM0  = 32'h9000_0000;
    localparam logic [31:0] A_UM3  = 32'h9000_0010;
    localparam logic [31:0] A_B2B1 = 32'h8400_0008;
    localparam logic [31:0] A_B2B2 = 32'h8400_000C;
    localparam logic [31:0] A_TMO  = 32'h8800_0000;
    localparam logic [31:0] A_RST  = 32'h8000_0100;
    localparam logic [31:0] A_AFT  = 32'h8000_0200;
    localparam logic [31:0] D_RD0  = 32'hCAFE_F00D;
    localparam logic [31:0] D_WR   = 32'h1234_5678;
    localparam logic [31:0] D_JUNK = 32'hDEAD_BEEF;
    localparam logic [31:0] D_SERR = 32'h5555_AAAA;
    localparam logic [31:0] D_B2B1 = 32'h0BAD_CAFE;
    localparam logic [31:0] D_B2B2 = 32'h1111_2222;
    localparam logic [31:0] D_AFT  = 32'h7777_8888;

    task automatic add(input string name, input logic v, input logic hw, input logic [31:0] ha,
                       input logic [2:0] sel, input logic [31:0] hwd, input logic [31:0] prd,
                       input logic prdy, input logic perr,
                       input logic [2:0] e_psel, input logic e_pen, input logic e_hready,
                       input logic e_hresp, input logic e_pwrite, input logic [31:0] e_paddr,
                       input logic [31:0] e_pwdata, input logic [31:0] e_hrdata);
        vec_t r;
        r.name = name; r.valid = v; r.hwrite = hw; r.haddr = ha; r.sel = sel;
        r.hwdata = hwd; r.prdata = prd; r.pready = prdy; r.pslverr = perr;
        r.e_psel = e_psel; r.e_pen = e_pen; r.e_hready = e_hready; r.e_hresp = e_hresp;
        r.e_pwrite = e_pwrite; r.e_paddr = e_paddr; r.e_pwdata = e_pwdata; r.e_hrdata = e_hrdata;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic hw, input logic [31:0] ha, input logic [2:0] sel,
                         input logic [31:0] hwd, input logic [31:0] prd, input logic prdy,
                         input logic perr);
        valid = v; Hwrite = hw; Haddr = ha; tempselx = sel;
        Hwdata = hwd; Prdata = prd; Pready = prdy; Pslverr = perr;
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [2:0] psel, input logic pen,
                           input logic hready, input logic hresp);
        chk({tag, ".pselx"}, 32'(Pselx), 32'(psel));
        chk({tag, ".penable"}, 32'(Penable), 32'(pen));
        chk({tag, ".hreadyout"}, 32'(Hreadyout), 32'(hready));
        chk({tag, ".hresp"}, 32'(Hresp), 32'(hresp));
    endtask

    initial begin
        Hresetn = 1'b0;
        drive(0, 0, '0, '0, '0, '0, 0, 0);

        //                                   v  w  haddr   sel     hwdata  prdata  rdy err  psel    pen hrdy rsp pw paddr   pwdata  hrdata
        add("rd0_setup",  1, 0, A_RD0,  3'b010, '0,     D_RD0,  1, 0, 3'b010, 0, 0, 0, 0, A_RD0,  '0,   '0);
        add("rd0_access", 0, 0, '0,     3'b000, '0,     D_RD0,  1, 0, 3'b010, 1, 0, 0, 0, A_RD0,  '0,   '0);
        add("rd0_done",   0, 0, '0,     3'b000, '0,     D_RD0,  1, 0, 3'b000, 0, 1, 0, 0, A_RD0,  '0,   D_RD0);
        add("wr3_wdata",  1, 1, A_WR3,  3'b001, '0,     '0,     0, 0, 3'b000, 0, 0, 0, 1, A_WR3,  '0,   D_RD0);
        add("wr3_setup",  0, 0, '0,     3'b000, D_WR,   '0,     0, 0, 3'b001, 0, 0, 0, 1, A_WR3,  D_WR, D_RD0);
        add("wr3_acc",    0, 0, '0,     3'b000, D_JUNK, '0,     0, 0, 3'b001, 1, 0, 0, 1, A_WR3,  D_WR, D_RD0);
        add("wr3_wait1",  0, 0, '0,     3'b000, D_JUNK, '0,     0, 0, 3'b001, 1, 0, 0, 1, A_WR3,  D_WR, D_RD0);
        add("wr3_wait2",  0, 0, '0,     3'b000, D_JUNK, '0,     0, 0, 3'b001, 1, 0, 0, 1, A_WR3,  D_WR, D_RD0);
        add("wr3_wait3",  0, 0, '0,     3'b000, D_JUNK, '0,     0, 0, 3'b001, 1, 0, 0, 1, A_WR3,  D_WR, D_RD0);
        add("wr3_done",   0, 0, '0,     3'b000, D_JUNK, D_JUNK, 1, 0, 3'b000, 0, 1, 0, 1, A_WR3,  D_WR, D_RD0);
        add("serr_setup", 1, 0, A_SERR, 3'b100, '0,     '0,     0, 0, 3'b100, 0, 0, 0, 0, A_SERR, D_WR, D_RD0);
        add("serr_acc",   0, 0, '0,     3'b000, '0,     '0,     0, 0, 3'b100, 1, 0, 0, 0, A_SERR, D_WR, D_RD0);
        add("serr_err1",  0, 0, '0,     3'b000, '0,     D_SERR, 1, 1, 3'b000, 0, 0, 1, 0, A_SERR, D_WR, D_RD0);
        add("serr_err2",  0, 0, '0,     3'b000, '0,     D_SERR, 0, 0, 3'b000, 0, 1, 1, 0, A_SERR, D_WR, D_RD0);
        add("serr_idle",  0, 0, '0,     3'b000, '0,     '0,     0, 0, 3'b000, 0, 1, 0, 0, A_SERR, D_WR, D_RD0);
        add("um0_err1",   1, 1, A_UM0,  3'b000, '0,     '0,     1, 0, 3'b000, 0, 0, 1, 1, A_UM0,  D_WR, D_RD0);
        add("um0_err2",   0, 0, '0,     3'b000, '0,     '0,     1, 0, 3'b000, 0, 1, 1, 1, A_UM0,  D_WR, D_RD0);
        add("um0_idle",   0, 0, '0,     3'b000, '0,     '0,     1, 0, 3'b000, 0, 1, 0, 1, A_UM0,  D_WR, D_RD0);
        add("um3_err1",   1, 0, A_UM3,  3'b011, '0,     '0,     1, 0, 3'b000, 0, 0, 1, 0, A_UM3,  D_WR, D_RD0);
        add("um3_err2",   0, 0, '0,     3'b000, '0,     '0,     1, 0, 3'b000, 0, 1, 1, 0, A_UM3,  D_WR, D_RD0);
        add("um3_idle",   0, 0, '0,     3'b000, '0,     '0,     1, 0, 3'b000, 0, 1, 0, 0, A_UM3,  D_WR, D_RD0);
        add("b2b1_setup", 1, 0, A_B2B1, 3'b010, '0,     '0,     1, 0, 3'b010, 0, 0, 0, 0, A_B2B1, D_WR, D_RD0);
        add("b2b1_acc",   0, 0, '0,     3'b000, '0,     '0,     1, 0, 3'b010, 1, 0, 0, 0, A_B2B1, D_WR, D_RD0);
        add("b2b1_done",  1, 0, A_B2B2, 3'b100, '0,     D_B2B1, 1, 0, 3'b000, 0, 1, 0, 0, A_B2B1, D_WR, D_B2B1);
        add("b2b2_setup", 1, 0, A_B2B2, 3'b100, '0,     D_B2B2, 1, 0, 3'b100, 0, 0, 0, 0, A_B2B2, D_WR, D_B2B1);
        add("b2b2_acc",   0, 0, '0,     3'b000, '0,     D_B2B2, 1, 0, 3'b100, 1, 0, 0, 0, A_B2B2, D_WR, D_B2B1);
        add("b2b2_done",  0, 0, '0,     3'b000, '0,     D_B2B2, 1, 0, 3'b000, 0, 1, 0, 0, A_B2B2, D_WR, D_B2B2);

        repeat (2) @(posedge Hclk);
        #1;
        chk_bus("reset", 3'b000, 0, 1, 0);
        chk("reset.paddr", Paddr, '0);
        chk("reset.pwdata", Pwdata, '0);
        chk("reset.pwrite", 32'(Pwrite), 0);
        chk("reset.hrdata", Hrdata, '0);
        $display("reset released");
        Hresetn = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].hwrite, tbl[i].haddr, tbl[i].sel,
                  tbl[i].hwdata, tbl[i].prdata, tbl[i].pready, tbl[i].pslverr);
            tick();
            chk_bus(tbl[i].name, tbl[i].e_psel, tbl[i].e_pen, tbl[i].e_hready, tbl[i].e_hresp);
            chk({tbl[i].name, ".pwrite"}, 32'(Pwrite), 32'(tbl[i].e_pwrite));
            chk({tbl[i].name, ".paddr"}, Paddr, tbl[i].e_paddr);
            chk({tbl[i].name, ".pwdata"}, Pwdata, tbl[i].e_pwdata);
            chk({tbl[i].name, ".hrdata"}, Hrdata, tbl[i].e_hrdata);
            $display("vector %0d %s", i, tbl[i].name);
        end

        // Timeout: Pready held low, four ACCESS cycles then abort into the error response.
        drive(1, 0, A_TMO, 3'b001, '0, D_JUNK, 0, 0);
        tick();
        chk_bus("tmo_setup", 3'b001, 0, 0, 0);
        drive(0, 0, '0, 3'b000, '0, D_JUNK, 0, 0);
        for (int k = 0; k < TIMEOUT; k++) begin
            tick();
            chk_bus($sformatf("tmo_access%0d", k), 3'b001, 1, 0, 0);
        end
        tick();
        chk_bus("tmo_err1", 3'b000, 0, 0, 1);
        tick();
        chk_bus("tmo_err2", 3'b000, 0, 1, 1);
        tick();
        chk_bus("tmo_idle", 3'b000, 0, 1, 0);
        chk("tmo_idle.hrdata", Hrdata, D_B2B2);
        $display("timeout sequence done");

        // Reset during a wait state, then a fresh read.
        drive(1, 0, A_RST, 3'b010, '0, '0, 0, 0);
        tick();
        drive(0, 0, '0, 3'b000, '0, '0, 0, 0);
        tick();
        tick();
        chk_bus("rst_wait", 3'b010, 1, 0, 0);
        Hresetn = 1'b0;
        tick();
        chk_bus("rst_applied", 3'b000, 0, 1, 0);
        chk("rst_applied.paddr", Paddr, '0);
        chk("rst_applied.pwdata", Pwdata, '0);
        chk("rst_applied.hrdata", Hrdata, '0);
        Hresetn = 1'b1;
        drive(1, 0, A_AFT, 3'b001, '0, D_AFT, 1, 0);
        tick();
        chk_bus("aft_setup", 3'b001, 0, 0, 0);
        chk("aft_setup.paddr", Paddr, A_AFT);
        drive(0, 0, '0, 3'b000, '0, D_AFT, 1, 0);
        tick();
        chk_bus("aft_access", 3'b001, 1, 0, 0);
        tick();
        chk_bus("aft_done", 3'b000, 0, 1, 0);
        chk("aft_done.hrdata", Hrdata, D_AFT);
        $display("reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
